// File: rtl/mac_pe.sv
// mac_pe: systolic multiply-accumulate PE; sums LEN unsigned a*b products
// and forwards each operand pair one cycle late to the next PE.
// Ports: clk, reset (async high), in_valid/a_in/b_in operand stream;
//   a_fwd/b_fwd/fwd_valid forwarded stream; acc_out/out_valid result;
//   busy while a vector is partially accumulated.
// Build option: define ACC_SAT_EN to clamp the accumulator instead of wrapping.
module mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int LEN    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_fwd,
  output logic [DATA_W-1:0] b_fwd,
  output logic              fwd_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  output logic              busy
);

  localparam int PW = 2 * DATA_W;
  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_out_d;
  logic             ov_d;
  logic             busy_d;

  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] step;

  assign prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
  assign prod_ext = ACC_W'(prod);

  // acc is always zero in IDLE, so the same adder serves the first pair
  // of a vector and every later one.
`ifdef ACC_SAT_EN
  logic [ACC_W:0] sum_w;
  logic           ovf;
  logic           sat_q;

  assign sum_w = {1'b0, acc_q} + {1'b0, prod_ext};
  assign ovf   = sum_w[ACC_W];
  assign step  = ovf ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];

  // Sticky per-vector record that clamping happened; cleared on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (ov_d) begin
      sat_q <= 1'b0;
    end else if (in_valid && ovf) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign step = acc_q + prod_ext;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_out_d = acc_out;
    ov_d      = 1'b0;
    busy_d    = busy;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = step;
          cnt_d   = CW'(1);
          busy_d  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          if (cnt_q == LAST) begin
            acc_out_d = step;
            ov_d      = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            acc_d = step;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      acc_out   <= acc_out_d;
      out_valid <= ov_d;
      busy      <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_fwd     <= '0;
      b_fwd     <= '0;
      fwd_valid <= 1'b0;
    end else begin
      a_fwd     <= a_in;
      b_fwd     <= b_in;
      fwd_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_mac_pe.sv
// tb_mac_pe: directed self-checking bench for mac_pe.
// Default instance plus a narrow ACC_W=17 instance for overflow.
module tb_mac_pe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [7:0]  a_fwd;
  logic [7:0]  b_fwd;
  logic        fwd_valid;
  logic [19:0] acc_out;
  logic        out_valid;
  logic        busy;

  logic [7:0]  a_fwd17;
  logic [7:0]  b_fwd17;
  logic        fwd_valid17;
  logic [16:0] acc_out17;
  logic        out_valid17;
  logic        busy17;

  int total;
  int bad;

  mac_pe #(.DATA_W(8), .ACC_W(20), .LEN(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in),
    .a_fwd(a_fwd), .b_fwd(b_fwd), .fwd_valid(fwd_valid),
    .acc_out(acc_out), .out_valid(out_valid), .busy(busy)
  );

  mac_pe #(.DATA_W(8), .ACC_W(17), .LEN(4)) dut17 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in),
    .a_fwd(a_fwd17), .b_fwd(b_fwd17), .fwd_valid(fwd_valid17),
    .acc_out(acc_out17), .out_valid(out_valid17), .busy(busy17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pair(input logic [7:0] a, input logic [7:0] b);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if (acc_out !== 20'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_out acc=%0d ov=%b busy=%b want 0 0 0",
               acc_out, out_valid, busy);
    end
    total++;
    if (a_fwd !== 8'd0 || b_fwd !== 8'd0 || fwd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_fwd a=%0d b=%0d v=%b want 0 0 0",
               a_fwd, b_fwd, fwd_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    gap();
  endtask

  task automatic test_nominal();
    pair(8'd1, 8'd3);
    total++;
    if (a_fwd !== 8'd1 || b_fwd !== 8'd3 || fwd_valid !== 1'b1) begin
      bad++;
      $display("FAIL nom_fwd a=%0d b=%0d v=%b want 1 3 1",
               a_fwd, b_fwd, fwd_valid);
    end
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL nom_busy busy=%b ov=%b want 1 0", busy, out_valid);
    end
    pair(8'd2, 8'd4);
    pair(8'd3, 8'd5);
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || a_fwd !== 8'd3) begin
      bad++;
      $display("FAIL nom_mid busy=%b ov=%b a_fwd=%0d want 1 0 3",
               busy, out_valid, a_fwd);
    end
    pair(8'd4, 8'd6);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 20'd50 || busy !== 1'b0) begin
      bad++;
      $display("FAIL nom_done ov=%b acc=%0d busy=%b want 1 50 0",
               out_valid, acc_out, busy);
    end
    gap();
    total++;
    if (out_valid !== 1'b0 || acc_out !== 20'd50 || fwd_valid !== 1'b0) begin
      bad++;
      $display("FAIL nom_hold ov=%b acc=%0d fv=%b want 0 50 0",
               out_valid, acc_out, fwd_valid);
    end
  endtask

  task automatic test_gap();
    int early;
    early = 0;
    pair(8'd1, 8'd3);
    early += int'(out_valid);
    pair(8'd2, 8'd4);
    early += int'(out_valid);
    gap();
    early += int'(out_valid);
    gap();
    early += int'(out_valid);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL gap_busy busy=%b want 1", busy);
    end
    pair(8'd3, 8'd5);
    early += int'(out_valid);
    total++;
    if (early !== 0) begin
      bad++;
      $display("FAIL gap_early pulses=%0d want 0", early);
    end
    pair(8'd4, 8'd6);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 20'd50) begin
      bad++;
      $display("FAIL gap_done ov=%b acc=%0d want 1 50", out_valid, acc_out);
    end
    gap();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) pair(8'd1, 8'd2);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 20'd8) begin
      bad++;
      $display("FAIL b2b_first ov=%b acc=%0d want 1 8", out_valid, acc_out);
    end
    pair(8'd5, 8'd5);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || acc_out !== 20'd8) begin
      bad++;
      $display("FAIL b2b_next ov=%b busy=%b acc=%0d want 0 1 8",
               out_valid, busy, acc_out);
    end
    for (int i = 0; i < 3; i++) pair(8'd5, 8'd5);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 20'd100) begin
      bad++;
      $display("FAIL b2b_second ov=%b acc=%0d want 1 100", out_valid, acc_out);
    end
    gap();
  endtask

  task automatic test_reset_mid();
    pair(8'd10, 8'd10);
    pair(8'd10, 8'd10);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || acc_out !== 20'd0 || out_valid !== 1'b0 ||
        a_fwd !== 8'd0 || b_fwd !== 8'd0 || fwd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async busy=%b acc=%0d ov=%b a=%0d b=%0d fv=%b want 0",
               busy, acc_out, out_valid, a_fwd, b_fwd, fwd_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    pair(8'd1, 8'd3);
    pair(8'd2, 8'd4);
    pair(8'd3, 8'd5);
    pair(8'd4, 8'd6);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 20'd50) begin
      bad++;
      $display("FAIL rmid_result ov=%b acc=%0d want 1 50", out_valid, acc_out);
    end
    gap();
  endtask

  task automatic test_max();
    logic [16:0] exp17;
`ifdef ACC_SAT_EN
    exp17 = 17'd131071;
`else
    exp17 = 17'd129028;
`endif
    for (int i = 0; i < 4; i++) pair(8'd255, 8'd255);
    total++;
    if (out_valid !== 1'b1 || acc_out !== 20'd260100) begin
      bad++;
      $display("FAIL max_default ov=%b acc=%0d want 1 260100",
               out_valid, acc_out);
    end
    total++;
    if (out_valid17 !== 1'b1 || acc_out17 !== exp17) begin
      bad++;
      $display("FAIL max_w17 ov=%b acc=%0d want 1 %0d",
               out_valid17, acc_out17, exp17);
    end
    gap();
  endtask

  initial begin
    total = 0;
    bad = 0;
    in_valid = 1'b0;
    a_in = 8'd0;
    b_in = 8'd0;
    reset = 1'b0;
    #2;
    test_reset();
    test_nominal();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    test_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_pe.md
Name: mac_pe

Overview:
- Processing element directly downstream of the operand-sequencing FSM.
- Consumes one (a, b) operand pair per cycle from the serialised a_out/b_out streams.
- Accumulates LEN unsigned products into one dot-product result and presents it with a one-cycle valid pulse.
- Re-registers the operand pair on forwarding outputs so PEs can be chained systolically.

Parameters:
- DATA_W, 8, operand width in bits.
- ACC_W, 20, accumulator/result width; must satisfy ACC_W >= 2*DATA_W + clog2(LEN) unless ACC_SAT_EN is defined.
- LEN, 4, products per dot product (2..16).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a_in/b_in carry a valid operand pair this cycle.
- a_in  input  DATA_W  operand A (unsigned).
- b_in  input  DATA_W  operand B (unsigned).
- a_fwd  output  DATA_W  a_in delayed one cycle, to the next PE.
- b_fwd  output  DATA_W  b_in delayed one cycle, to the next PE.
- fwd_valid  output  1  in_valid delayed one cycle.
- acc_out  output  ACC_W  completed dot product; held until the next completion.
- out_valid  output  1  one-cycle pulse when acc_out updates.
- busy  output  1  high while a dot product is partially accumulated.

Behaviour:
- Reset (async, active-high): state=IDLE, acc=0, count=0, acc_out=0, out_valid=0, busy=0, a_fwd=0, b_fwd=0, fwd_valid=0. Outputs take these values immediately on assertion, not at the next edge.
- Forwarding path: every clock edge, a_fwd<=a_in, b_fwd<=b_in, fwd_valid<=in_valid, independent of state. Latency is 1 cycle.
- Product: unsigned a_in*b_in at 2*DATA_W bits, zero-extended to ACC_W.
- States are IDLE and ACC.
- IDLE:
  - in_valid=1 -> acc<=product, count<=1, go to ACC, busy<=1.
  - If LEN were 1 this would complete immediately, but LEN>=2 is required.
  - in_valid=0 -> stay in IDLE.
- ACC:
  - in_valid=0 -> hold acc and count (gaps are allowed, no timeout).
  - in_valid=1 and count<LEN-1 -> acc<=acc+product, count<=count+1.
  - in_valid=1 and count==LEN-1 (last pair) -> acc_out<=acc+product, out_valid<=1 for exactly the next cycle, acc<=0, count<=0, busy<=0, go to IDLE.
- Latency: acc_out/out_valid become visible 1 cycle after the edge that samples the LEN-th valid pair.
- Back-to-back vectors: an in_valid pair on the cycle immediately after the last pair (while out_valid is high) is the first element of the next vector. No bubble is required and no pair is dropped.
- out_valid is never high for two consecutive cycles unless two vectors complete back-to-back; with LEN>=2 that cannot happen.
- acc_out holds its value between completions. It is not cleared on IDLE entry, only on reset.
- Overflow with ACC_SAT_EN undefined: addition wraps modulo 2^ACC_W.
- Reset mid-accumulation: the partial sum is discarded and the first valid pair after reset deassertion starts a fresh vector.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: each accumulate step clamps to 2^ACC_W-1 if the true sum exceeds it. acc_out is then saturated, and a sticky internal flag is set for the vector and cleared at completion; the flag is not a port.
- Undefined: the accumulator wraps modulo 2^ACC_W, and no saturation logic is synthesised.

Test Plan:
- Nominal: reset, then a=1,2,3,4 and b=3,4,5,6 on 4 consecutive in_valid cycles -> out_valid pulses once, 1 cycle after the 4th pair, with acc_out=50; busy is high for cycles 1-4; a_fwd/b_fwd mirror the inputs 1 cycle late.
- Gapped input: same vector with in_valid low for 2 cycles between pairs 2 and 3 -> acc_out=50, out_valid 1 cycle after the 4th valid pair, no early pulse.
- Back-to-back: vectors (1,1,1,1)x(2,2,2,2) then immediately (5,5,5,5)x(5,5,5,5), 8 consecutive valid cycles -> out_valid after cycle 4 with acc_out=8, and after cycle 8 with acc_out=100.
- Reset mid-operation: 2 pairs (10x10, 10x10), assert reset 1 cycle, then vector 1,2,3,4 x 3,4,5,6 -> all outputs 0 during reset; next result is acc_out=50 (not 250).
- Max values at defaults: all pairs 255x255 -> acc_out=260100, no wrap.
- Overflow with ACC_W=17, all pairs 255x255 -> with ACC_SAT_EN acc_out=131071; without it acc_out=129028.
